// File: rtl/vigna_prefetch.sv
// vigna_prefetch: DEPTH-entry instruction prefetch queue for vigna RV32I.
// Speaks i_valid/i_ready toward memory and valid/ready toward the core.
module vigna_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         resetn,
  output logic                         i_valid,
  input  logic                         i_ready,
  output logic [31:0]                  i_addr,
  input  logic [31:0]                  i_rdata,
  output logic                         f_valid,
  input  logic                         f_ready,
  output logic [31:0]                  f_inst,
  output logic [31:0]                  f_pc,
  input  logic                         redir,
  input  logic [31:0]                  redir_addr,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nx;
  logic [31:0]     fetch_addr;
  logic [31:0]     pend_addr;
  logic [31:0]     redir_al;
  logic            push;
  logic            pop;
  logic            room;

  assign redir_al = redir_addr & ~32'h3;
  assign push     = (state == REQ) & i_ready & ~redir;
  assign pop      = (count != '0) & f_ready & ~redir;
  assign room     = count_nx < FULL;

  always_comb begin
    count_nx = count;
    if (redir)
      count_nx = '0;
    else if (push & ~pop)
      count_nx = count + CW'(1);
    else if (pop & ~push)
      count_nx = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (redir || room)
          state_nx = REQ;
      REQ:
        if (redir)
          state_nx = i_ready ? REQ : DISCARD;
        else if (i_ready && !room)
          state_nx = IDLE;
      DISCARD:
        if (i_ready)
          state_nx = REQ;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    i_valid   = (state != IDLE);
    i_addr    = fetch_addr;
    f_valid   = (count != '0);
    f_inst    = '0;
    f_pc      = '0;
    occupancy = count;
    if (f_valid) begin
      f_inst = inst_mem[rd_ptr];
      f_pc   = pc_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fetch_addr <= RESET_ADDR;
      pend_addr  <= '0;
    end else begin
      count <= count_nx;
      if (redir)
        rd_ptr <= wr_ptr;
      else if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      // i_addr is fetch_addr, so it stays put until the bus completes
      unique case (state)
        IDLE:
          if (redir)
            fetch_addr <= redir_al;
        REQ:
          if (i_ready)
            fetch_addr <= redir ? redir_al : fetch_addr + 32'd4;
          else if (redir)
            pend_addr <= redir_al;
        DISCARD:
          if (i_ready)
            fetch_addr <= redir ? redir_al : pend_addr;
          else if (redir)
            pend_addr <= redir_al;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_addr;
      inst_mem[wr_ptr] <= i_rdata;
    end
  end

endmodule

// File: tb/tb_vigna_prefetch.sv
// tb_vigna_prefetch: scoreboard bench for vigna_prefetch.
// Memory model with wait states, queue model, directed vector table.
module tb_vigna_prefetch;

  localparam logic [31:0] RST = 32'h0000_0100;

  logic        clk;
  logic        resetn;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_inst;
  logic [31:0] f_pc;
  logic        redir;
  logic [31:0] redir_addr;
  logic [2:0]  occupancy;

  vigna_prefetch #(
    .DEPTH(4),
    .RESET_ADDR(RST)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .f_valid(f_valid),
    .f_ready(f_ready),
    .f_inst(f_inst),
    .f_pc(f_pc),
    .redir(redir),
    .redir_addr(redir_addr),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic        fr;
    logic        rd;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] ia;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] occ;
  } vec_t;

  ent_t        sb[$];
  logic [31:0] exp_pc;
  logic        disc;
  int          checks;
  int          failures;
  int          hs_cnt;
  int          wcnt;
  int          waits;
  logic        seen300;
  logic        seen400;
  vec_t        vt[10];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a ^ 32'hDEAD_BEEF) + {a[15:0], 16'h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic rdy, input logic fr, input logic rd,
                       input logic [31:0] ra);
    i_ready    = rdy;
    i_rdata    = rdy ? mem(i_addr) : 32'h0;
    f_ready    = fr;
    redir      = rd;
    redir_addr = ra;
    if (!resetn) begin
      sb.delete();
      exp_pc = RST;
      disc   = 1'b0;
    end else if (rd) begin
      sb.delete();
      disc   = i_valid && !rdy;
      exp_pc = ra & ~32'h3;
    end else begin
      if (fr && sb.size() > 0)
        void'(sb.pop_front());
      if (i_valid && rdy) begin
        if (disc) begin
          disc = 1'b0;
        end else begin
          chk("hs_addr", i_addr, exp_pc);
          sb.push_back('{exp_pc, mem(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    if (resetn && i_valid && rdy)
      hs_cnt++;
    if (resetn && i_valid && !rdy)
      wcnt++;
    else
      wcnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("occupancy", 32'(occupancy), 32'(sb.size()));
    chk("f_valid", 32'(f_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("f_pc", f_pc, sb[0].pc);
      chk("f_inst", f_inst, sb[0].inst);
    end else begin
      chk("f_pc_idle", f_pc, 32'h0);
      chk("f_inst_idle", f_inst, 32'h0);
    end
  endtask

  task automatic tick(input logic fr, input logic rd, input logic [31:0] ra);
    logic rdy;
    rdy = resetn && i_valid && (wcnt >= waits);
    cycle(rdy, fr, rd, ra);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; hs_cnt = 0; wcnt = 0; waits = 0;
    exp_pc = RST; disc = 1'b0;
    resetn = 1'b0; i_ready = 1'b0; i_rdata = '0;
    f_ready = 1'b0; redir = 1'b0; redir_addr = '0;

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'd0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'd1};
    vt[2] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 32'd2};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'h503, 1'b1, 32'h500, 1'b0, 32'h0,   32'd0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h504, 1'b1, 32'h500, 32'd1};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h508, 1'b1, 32'h504, 32'd1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h508, 1'b0, 32'h0,   32'd0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h508, 1'b0, 32'h0,   32'd0};
    vt[8] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h600, 1'b0, 32'h0,   32'd0};
    vt[9] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h604, 1'b1, 32'h600, 32'd1};

    // reset values and first request
    do_reset();
    chk("rst_i_valid", 32'(i_valid), 32'h0);
    chk("rst_i_addr", i_addr, RST);
    chk("rst_f_valid", 32'(f_valid), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    chk("c0_i_valid", 32'(i_valid), 32'h1);
    chk("c0_i_addr", i_addr, RST);

    // zero-wait streaming
    waits = 0; hs_cnt = 0;
    repeat (12) tick(1'b1, 1'b0, 32'h0);
    chk("stream_hs", 32'(hs_cnt), 32'd12);
    chk("stream_pc", f_pc, 32'h12C);

    // fill to DEPTH, then drain and refill
    do_reset();
    hs_cnt = 0;
    repeat (10) tick(1'b0, 1'b0, 32'h0);
    chk("full_hs", 32'(hs_cnt), 32'd4);
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_i_valid", 32'(i_valid), 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    chk("unfull_i_valid", 32'(i_valid), 32'h1);
    chk("unfull_i_addr", i_addr, 32'h110);
    repeat (10) tick(1'b1, 1'b0, 32'h0);

    // wait states, redirect while 0x108 is in flight
    waits = 3;
    do_reset();
    for (int n = 0; n < 60 && !(i_valid && i_addr == 32'h108); n++)
      tick(1'b1, 1'b0, 32'h0);
    chk("ws_issue_108", i_addr, 32'h108);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h200);
    chk("ws_hold_valid", 32'(i_valid), 32'h1);
    for (int n = 0; n < 20 && disc; n++) begin
      chk("ws_hold_addr", i_addr, 32'h108);
      tick(1'b1, 1'b0, 32'h0);
    end
    chk("ws_after_drop", i_addr, 32'h200);
    for (int n = 0; n < 20 && !f_valid; n++)
      tick(1'b1, 1'b0, 32'h0);
    chk("ws_first_pc", f_pc, 32'h200);

    // directed vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].rdy, vt[i].fr, vt[i].rd, vt[i].ra);
      chk($sformatf("vec%0d_i_valid", i), 32'(i_valid), 32'(vt[i].iv));
      chk($sformatf("vec%0d_i_addr", i), i_addr, vt[i].ia);
      chk($sformatf("vec%0d_f_valid", i), 32'(f_valid), 32'(vt[i].fv));
      chk($sformatf("vec%0d_f_pc", i), f_pc, vt[i].pc);
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), vt[i].occ);
    end

    // two redirects during one pending request
    waits = 4;
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    seen300 = 1'b0; seen400 = 1'b0;
    tick(1'b1, 1'b1, 32'h300);
    tick(1'b1, 1'b1, 32'h400);
    for (int n = 0; n < 25; n++) begin
      if (i_valid && i_addr == 32'h300) seen300 = 1'b1;
      if (i_valid && i_addr == 32'h400) seen400 = 1'b1;
      tick(1'b1, 1'b0, 32'h0);
    end
    chk("dbl_no_300", 32'(seen300), 32'h0);
    chk("dbl_saw_400", 32'(seen400), 32'h1);

    // address wrap at the top of memory
    waits = 0;
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("wrap_fff8", i_addr, 32'hFFFF_FFF8);
    tick(1'b1, 1'b0, 32'h0);
    chk("wrap_fffc", i_addr, 32'hFFFF_FFFC);
    tick(1'b1, 1'b0, 32'h0);
    chk("wrap_zero", i_addr, 32'h0);
    tick(1'b1, 1'b0, 32'h0);

    // reset in the middle of a waited request
    waits = 3;
    tick(1'b1, 1'b0, 32'h0);
    resetn = 1'b0;
    tick(1'b1, 1'b0, 32'h0);
    chk("mid_rst_i_valid", 32'(i_valid), 32'h0);
    chk("mid_rst_i_addr", i_addr, RST);
    chk("mid_rst_f_valid", 32'(f_valid), 32'h0);
    chk("mid_rst_f_inst", f_inst, 32'h0);
    chk("mid_rst_f_pc", f_pc, 32'h0);
    chk("mid_rst_occ", 32'(occupancy), 32'h0);
    resetn = 1'b1;
    tick(1'b1, 1'b0, 32'h0);
    chk("post_rst_i_valid", 32'(i_valid), 32'h1);
    chk("post_rst_i_addr", i_addr, RST);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vigna_prefetch.md
# vigna_prefetch

Parametrised instruction prefetch unit for the vigna RV32I core family. It replaces the single-entry fetch state machine with a DEPTH-entry instruction queue that issues sequential fetches ahead of execution. On the bus side it speaks the vigna i_valid/i_ready fetch protocol; on the core side it speaks a valid/ready handshake, and it accepts a redirect (jump/branch) that flushes the queue.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_ADDR, 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- i_valid  out  1  fetch request valid.
- i_ready  in  1  memory completes the request this cycle; i_rdata valid.
- i_addr  out  32  fetch address; stable while i_valid=1 and i_ready=0.
- i_rdata  in  32  fetched instruction word.
- f_valid  out  1  queue head valid.
- f_ready  in  1  core consumes the head this cycle.
- f_inst  out  32  head instruction; 0 when f_valid=0.
- f_pc  out  32  head address; 0 when f_valid=0.
- redir  in  1  flush the queue and restart fetch at redir_addr.
- redir_addr  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- occupancy  out  $clog2(DEPTH+1)  number of valid queue entries.

## Operation
- State:
  - queue of {pc, inst} entries, with rd_ptr/wr_ptr of width log2(DEPTH) that wrap modulo DEPTH;
  - count, 0..DEPTH;
  - fetch_addr;
  - discard flag;
  - pend_addr register.
- Bus FSM states:
  - IDLE: i_valid=0.
  - REQ: i_valid=1, i_addr=fetch_addr.
  - DISCARD: i_valid=1, request in flight whose data will be dropped.
- IDLE→REQ: when no redirect is pending and count_next<DEPTH.
  - count_next is count after this cycle's push/pop.
- REQ, i_ready=1, no redir:
  - push {fetch_addr, i_rdata};
  - fetch_addr += 4, wrapping 32'hFFFF_FFFC→0;
  - stay in REQ if count_next<DEPTH, else go to IDLE.
- REQ, i_ready=0: hold i_addr and i_valid; the request is never withdrawn.
- redir=1 (highest priority):
  - count←0 and rd_ptr←wr_ptr;
  - any same-cycle pop and push are ignored.
- redir=1 while in REQ with i_ready=0:
  - pend_addr←redir_addr;
  - go to DISCARD, keeping i_addr unchanged.
- DISCARD, i_ready=1:
  - drop the data;
  - fetch_addr←pend_addr;
  - go to REQ next cycle.
  - A further redir during DISCARD overwrites pend_addr (last redirect wins).
- redir=1 in IDLE, or in REQ with i_ready=1: the response, if any, is dropped; fetch_addr←redir_addr; next state is REQ.
- Pop: when f_valid & f_ready & !redir, advance rd_ptr and decrement count.
  - Simultaneous push and pop leaves count unchanged.
- f_valid = (count≠0). f_inst and f_pc come combinationally from the head entry.
- Reset values:
  - i_valid=0, i_addr=RESET_ADDR;
  - f_valid=0, f_inst=0, f_pc=0, occupancy=0;
  - FSM=IDLE, discard cleared.
  - Reset mid-transaction abandons the request.

## Timing
- At most one outstanding bus request.
- Cycle 0 is the first edge with resetn=1; i_valid=1 with i_addr=RESET_ADDR after cycle 0.
- Zero-wait memory sustains one fetch per cycle:
  - the response accepted at edge n gives f_valid=1 after edge n;
  - the next address is presented after edge n.
- Redirect latency with no request in flight and i_ready tied high:
  - redir sampled at edge k;
  - i_addr=redir_addr after k;
  - data accepted at k+1;
  - f_valid=1 with f_pc=redir_addr after k+1.
- Redirect with a request in flight: an additional delay equal to the remaining wait cycles of that request.
- Queue full (count=DEPTH): i_valid=0 from the next cycle. A pop while full lets i_valid assert after that edge.
- f_valid never shows a stale entry: it is 0 on the cycle after redir.

## Test plan
- Reset, i_ready=1, f_ready=1, RESET_ADDR=0x100 → f_pc sequence 0x100, 0x104, 0x108… one per cycle; f_inst matches the memory model.
- f_ready=0, DEPTH=4 → occupancy reaches 4, i_valid drops, exactly 4 bus requests; then f_ready=1 → 4 entries in order, then refill.
- Memory with 3 wait states; redir to 0x200 one cycle after the request to 0x108 is issued → 0x108 is held until i_ready, its data is discarded, the next i_addr is 0x200, and the first f_pc after the redirect is 0x200.
- redir on the same cycle as i_ready and f_ready with count=2 → occupancy=0 next cycle, no entry pushed, next i_addr=redir_addr.
- Two redirs (0x300, then 0x400) during one pending request → only 0x400 is fetched and 0x300 never appears on i_addr.
- fetch_addr=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; resetn low mid-request → all outputs take their reset values next cycle.
